reg_read_arbiter: RTL and testbench

Shares the single two-operand register-file read port among `NUM_REQ` requesters (reservation stations / issue slots) using round-robin arbitration. It sits between the issue stage and the register file's value-read port, which carries `src_1`/`src_2` out and `data_1`/`data_2`/`valid_1`/`valid_2` back. Each granted request gets a registered response tagged to the requester, two cycles after the grant. Flush kills all in-flight reads.

---
 rtl/reg_read_arbiter_pkg.sv | 20 ++
 rtl/reg_read_arbiter_if.sv | 41 ++++
 rtl/reg_read_arbiter_rr_arbiter.sv | 37 +++
 rtl/reg_read_arbiter.sv | 99 +++++++++
 tb/tb_reg_read_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_read_arbiter_pkg.sv
// Shared types for the register-file read arbiter: sizes, address/id types, response record.
// Types only; no logic, so no latency and no backpressure.
package reg_read_arbiter_pkg;

    localparam int RRA_NUM_REQ = 4;
    localparam int RRA_REG_W   = 6;
    localparam int RRA_XLEN    = 32;

    typedef logic [$clog2(RRA_NUM_REQ)-1:0] req_id_t;
    typedef logic [RRA_REG_W-1:0]           reg_addr_t;
    typedef logic [RRA_XLEN-1:0]            data_t;

    typedef struct packed {
        data_t data_1;
        data_t data_2;
        logic  ready_1;
        logic  ready_2;
    } rsp_t;

endpackage

// File: rtl/reg_read_arbiter_if.sv
// Requester and register-file read-port bundle; slave = arbiter, master = issue stage / RF side.
// Wires only; grant is combinational, rf_src and rsp are registered by the arbiter.
interface reg_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int REG_W   = 6,
    parameter int XLEN    = 32
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][REG_W-1:0] req_src_1;
    logic [NUM_REQ-1:0][REG_W-1:0] req_src_2;
    logic [NUM_REQ-1:0]            grant;

    logic [REG_W-1:0]              rf_src_1;
    logic [REG_W-1:0]              rf_src_2;
    logic [XLEN-1:0]               rf_data_1;
    logic [XLEN-1:0]               rf_data_2;
    logic                          rf_valid_1;
    logic                          rf_valid_2;

    logic [NUM_REQ-1:0]            rsp_valid;
    logic [XLEN-1:0]               rsp_data_1;
    logic [XLEN-1:0]               rsp_data_2;
    logic                          rsp_ready_1;
    logic                          rsp_ready_2;

    modport slave (
        input  req_valid, req_src_1, req_src_2,
        input  rf_data_1, rf_data_2, rf_valid_1, rf_valid_2,
        output grant, rf_src_1, rf_src_2,
        output rsp_valid, rsp_data_1, rsp_data_2, rsp_ready_1, rsp_ready_2
    );

    modport master (
        output req_valid, req_src_1, req_src_2,
        output rf_data_1, rf_data_2, rf_valid_1, rf_valid_2,
        input  grant, rf_src_1, rf_src_2,
        input  rsp_valid, rsp_data_1, rsp_data_2, rsp_ready_1, rsp_ready_2
    );

endinterface

// File: rtl/reg_read_arbiter_rr_arbiter.sv
// Round-robin pick of the first request at or after ptr (wrapping); purely combinational, zero latency.
// No backpressure: enable low forces an empty grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       any_grant
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] idx;

    // Walk from the farthest offset down so the nearest candidate to ptr is written last and wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx       = '0;
        if (enable) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = ptr + IDW'(k);
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_id   = idx;
                    any_grant  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_read_arbiter.sv
// Round-robin sharing of the two-operand RF read port; response two cycles after grant.
// Never stalls: one grant per cycle, no response backpressure, flush/reset drop in-flight reads.
module reg_read_arbiter
    import reg_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = RRA_NUM_REQ,
    parameter int REG_W   = RRA_REG_W,
    parameter int XLEN    = RRA_XLEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    reg_read_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     grant_id;
    logic [NUM_REQ-1:0] grant;
    logic               any_grant;
    logic               arb_en;

    logic               s1_v;
    logic [IDW-1:0]     s1_id;
    reg_addr_t          rf_src_1_q;
    reg_addr_t          rf_src_2_q;

    logic [NUM_REQ-1:0] rsp_valid_q;
    rsp_t               rsp_q;
    rsp_t               rf_rsp;

    assign arb_en = !flush && !reset;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .enable    (arb_en),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    assign rf_rsp = '{
        data_1:  data_t'(bus.rf_data_1),
        data_2:  data_t'(bus.rf_data_2),
        ready_1: bus.rf_valid_1,
        ready_2: bus.rf_valid_2
    };

    // Stage 1: address launch to the RF and pointer update on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            s1_v       <= 1'b0;
            s1_id      <= '0;
            rf_src_1_q <= '0;
            rf_src_2_q <= '0;
        end else begin
            s1_v  <= any_grant;
            s1_id <= grant_id;
            if (any_grant) begin
                ptr        <= grant_id + IDW'(1);
                rf_src_1_q <= reg_addr_t'(bus.req_src_1[grant_id]);
                rf_src_2_q <= reg_addr_t'(bus.req_src_2[grant_id]);
            end
        end
    end

    // Stage 2: capture RF data; flush in this cycle kills the read still in stage 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (s1_v && !flush) begin
                rsp_valid_q[s1_id] <= 1'b1;
            end
            rsp_q <= rf_rsp;
        end
    end

    assign bus.grant       = grant;
    assign bus.rf_src_1    = REG_W'(rf_src_1_q);
    assign bus.rf_src_2    = REG_W'(rf_src_2_q);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data_1  = XLEN'(rsp_q.data_1);
    assign bus.rsp_data_2  = XLEN'(rsp_q.data_2);
    assign bus.rsp_ready_1 = rsp_q.ready_1;
    assign bus.rsp_ready_2 = rsp_q.ready_2;

    a_grant_onehot : assert property (@(posedge clk) $onehot0(grant));
    a_rsp_onehot   : assert property (@(posedge clk) $onehot0(rsp_valid_q));
    a_no_grant_rst : assert property (@(posedge clk) (reset || flush) |-> (grant == '0));

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed bench for reg_read_arbiter: grant order, latency, wrap, idle, flush and reset cases.
module tb_reg_read_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    reg_read_arbiter_if #(.NUM_REQ(4), .REG_W(6), .XLEN(32)) bus ();

    reg_read_arbiter #(
        .NUM_REQ (4),
        .REG_W   (6),
        .XLEN    (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
    int         exp_id [5] = '{0, 1, 2, 3, 1};

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        bus.req_valid  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus.req_src_1[i] = 6'(10 + i);
            bus.req_src_2[i] = 6'(20 + i);
        end
        bus.rf_data_1  = 32'hDEAD;
        bus.rf_data_2  = 32'hBEEF;
        bus.rf_valid_1 = 1'b1;
        bus.rf_valid_2 = 1'b1;

        // Reset state, with requests present
        cyc(); cyc(); #1;
        chk("rst_grant",  bus.grant,       0);
        chk("rst_rsp",    bus.rsp_valid,   0);
        chk("rst_data1",  bus.rsp_data_1,  0);
        chk("rst_ready1", bus.rsp_ready_1, 0);
        chk("rst_src1",   bus.rf_src_1,    0);
        chk("rst_ptr",    dut.ptr,         0);

        // Single request from requester 2
        cyc();
        reset = 1'b0;
        bus.req_valid    = 4'b0100;
        bus.req_src_1[2] = 6'd5;
        bus.req_src_2[2] = 6'd9;
        #1;
        chk("one_grant", bus.grant, 4'b0100);
        cyc();
        bus.req_valid  = 4'b0000;
        bus.rf_data_1  = 32'hA5;
        bus.rf_data_2  = 32'h3C;
        bus.rf_valid_1 = 1'b1;
        bus.rf_valid_2 = 1'b0;
        #1;
        chk("one_src1", bus.rf_src_1,  5);
        chk("one_src2", bus.rf_src_2,  9);
        chk("one_ptr",  dut.ptr,       3);
        chk("one_rsp0", bus.rsp_valid, 0);
        cyc();
        bus.rf_data_1  = 32'h0;
        bus.rf_data_2  = 32'h0;
        bus.rf_valid_1 = 1'b1;
        bus.rf_valid_2 = 1'b1;
        #1;
        chk("one_rsp",    bus.rsp_valid,   4'b0100);
        chk("one_data1",  bus.rsp_data_1,  32'hA5);
        chk("one_data2",  bus.rsp_data_2,  32'h3C);
        chk("one_ready1", bus.rsp_ready_1, 1);
        chk("one_ready2", bus.rsp_ready_2, 0);

        // Search wraps: ptr=3, only requester 1
        cyc();
        bus.req_valid = 4'b0010;
        #1;
        chk("wrap_grant", bus.grant, 4'b0010);
        cyc();
        bus.req_valid = 4'b0000;
        #1;
        chk("wrap_ptr", dut.ptr, 2);
        cyc(); #1;
        chk("wrap_rsp", bus.rsp_valid, 4'b0010);

        // Idle cycles hold state
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            chk("idle_grant", bus.grant,     0);
            chk("idle_rsp",   bus.rsp_valid, 0);
            chk("idle_ptr",   dut.ptr,       2);
            chk("idle_src1",  bus.rf_src_1,  11);
            chk("idle_src2",  bus.rf_src_2,  21);
        end

        // All four requesting from reset, then only requester 1 after granting 3
        bus.req_src_1[2] = 6'd12;
        bus.req_src_2[2] = 6'd22;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) cyc();
            bus.req_valid  = (c < 4) ? 4'hF : ((c == 4) ? 4'b0010 : 4'h0);
            bus.rf_data_1  = 32'h100 + 32'(c);
            bus.rf_data_2  = 32'h200 + 32'(c);
            bus.rf_valid_1 = c[0];
            #1;
            chk("rr_grant", bus.grant, (c < 5) ? exp_g[c] : 4'h0);
            if (c >= 1 && c <= 5) chk("rr_src1", bus.rf_src_1, 10 + exp_id[c-1]);
            if (c >= 2) begin
                chk("rr_rsp",   bus.rsp_valid,   exp_g[c-2]);
                chk("rr_data1", bus.rsp_data_1,  32'h100 + 32'(c - 1));
                chk("rr_data2", bus.rsp_data_2,  32'h200 + 32'(c - 1));
                chk("rr_rdy1",  bus.rsp_ready_1, (c - 1) % 2);
            end else begin
                chk("rr_rsp_early", bus.rsp_valid, 0);
            end
            if (c == 5) chk("rr_wrap_ptr", dut.ptr, 2);
        end

        // Flush one cycle after a grant
        cyc();
        bus.req_valid = 4'b1000;
        #1;
        chk("fl_pre_grant", bus.grant, 4'b1000);
        cyc();
        bus.req_valid = 4'b0001;
        #1;
        chk("fl_t_grant", bus.grant, 4'b0001);
        cyc();
        flush = 1'b1;
        bus.req_valid = 4'b0010;
        #1;
        chk("fl_block",   bus.grant,     0);
        chk("fl_old_rsp", bus.rsp_valid, 4'b1000);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_kill",   bus.rsp_valid, 0);
        chk("fl_resume", bus.grant,     4'b0010);
        chk("fl_ptr",    dut.ptr,       1);
        cyc();
        bus.req_valid = 4'b0000;
        #1;
        chk("fl_gap", bus.rsp_valid, 0);
        cyc(); #1;
        chk("fl_after", bus.rsp_valid, 4'b0010);

        // Reset with two reads in flight
        cyc();
        bus.req_valid = 4'hF;
        #1;
        chk("mr_g0", bus.grant, 4'b0100);
        cyc(); #1;
        chk("mr_g1", bus.grant, 4'b1000);
        cyc();
        reset = 1'b1;
        bus.rf_data_1 = 32'h777;
        #1;
        chk("mr_grant", bus.grant, 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("mr_rsp",    bus.rsp_valid,   0);
        chk("mr_data1",  bus.rsp_data_1,  0);
        chk("mr_ready1", bus.rsp_ready_1, 0);
        chk("mr_src1",   bus.rf_src_1,    0);
        chk("mr_ptr",    dut.ptr,         0);
        chk("mr_first",  bus.grant,       4'b0001);
        cyc();
        bus.req_valid = 4'h0;
        #1;
        chk("mr_drop", bus.rsp_valid, 0);
        cyc(); #1;
        chk("mr_rsp_new", bus.rsp_valid, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
